// File: rtl/loader_pkg.sv
// Shared definitions for the instruction-memory program loader.
//   - FSM state encodings (plain constants so older tools see fixed codes)
//   - SYNC_BYTE  : default frame start byte
//   - WORD_BYTES : bytes packed into one instruction word
package loader_pkg;

  typedef logic [2:0] state_t;

  localparam state_t IDLE   = 3'd0;
  localparam state_t CNT_LO = 3'd1;
  localparam state_t CNT_HI = 3'd2;
  localparam state_t DATA   = 3'd3;
  localparam state_t WRITE  = 3'd4;
  localparam state_t DONE   = 3'd5;

  localparam logic [7:0] SYNC_BYTE  = 8'hA5;
  localparam int         WORD_BYTES = 4;

endpackage

// File: rtl/byte_word_packer.sv
// Packs a byte stream into little-endian 32-bit words.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   clr        : clear shift register and byte counter (start of frame)
//   shift      : shift byte_in into the word this cycle
//   byte_in    : incoming byte
//   word_out   : current contents of the shift register
//   last       : the shift in progress fills the final byte of the word
module byte_word_packer
  import loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        shift,
  input  logic [7:0]  byte_in,
  output logic [31:0] word_out,
  output logic        last
);

  logic [1:0] byte_cnt;

  // New bytes enter at the top so the first byte ends up in bits [7:0].
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_out <= '0;
      byte_cnt <= '0;
    end else if (clr) begin
      word_out <= '0;
      byte_cnt <= '0;
    end else if (shift) begin
      word_out <= {byte_in, word_out[31:8]};
      byte_cnt <= byte_cnt + 2'd1;
    end
  end

  assign last = shift && (byte_cnt == 2'(WORD_BYTES - 1));

endmodule

// File: rtl/inst_mem_loader.sv
// Program loader: receives a framed byte stream (SYNC, count_lo, count_hi,
// 4*N data bytes), writes the packed words to consecutive instruction RAM
// word addresses from 0, and freezes the CPU while a load is in progress.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   in_valid   : byte-stream valid
//   in_data    : byte-stream data
//   in_ready   : loader accepts a byte this cycle
//   mem_we     : instruction RAM write enable (registered)
//   mem_addr   : byte address {word_idx, 2'b00}
//   mem_wdata  : assembled instruction word
//   cpu_hold   : fetch freeze / pipeline hold
//   load_done  : one-cycle pulse at frame completion
//   overflow   : sticky, frame had more words than the RAM holds
//
// state  | meaning
// IDLE   | hunting for SYNC, other bytes dropped
// CNT_LO | waiting for count[7:0]
// CNT_HI | waiting for count[15:8]
// DATA   | collecting bytes of the current word
// WRITE  | one-cycle RAM write slot, input stalled
// DONE   | one-cycle load_done pulse
module inst_mem_loader
  import loader_pkg::*;
#(
  parameter int         ADDR_W = 10,
  parameter logic [7:0] SYNC   = SYNC_BYTE
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        cpu_hold,
  output logic        load_done,
  output logic        overflow
);

  localparam logic [16:0] DEPTH = 17'(1) << ADDR_W;

  state_t      state;
  logic [15:0] count;
  // Also serves as the words-received count: both start at zero per frame
  // and advance together, so one register is enough.
  logic [15:0] word_idx;
  logic        accept;
  logic        pk_clr;
  logic        pk_shift;
  logic        pk_last;
  logic [31:0] pk_word;
  logic [31:0] next_word;

  assign in_ready  = state inside {IDLE, CNT_LO, CNT_HI, DATA};
  assign cpu_hold  = (state != IDLE);
  assign load_done = (state == DONE);
  assign accept    = in_valid && in_ready;
  assign pk_clr    = (state == IDLE) && accept && (in_data == SYNC);
  assign pk_shift  = (state == DATA) && accept;

  // The word is registered into mem_wdata on the same edge that takes the
  // fourth byte, so the completed word is formed here rather than waiting
  // for the packer register to catch up.
  assign next_word = {in_data, pk_word[31:8]};

  byte_word_packer u_packer (
    .clk      (clk),
    .rst      (rst),
    .clr      (pk_clr),
    .shift    (pk_shift),
    .byte_in  (in_data),
    .word_out (pk_word),
    .last     (pk_last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      count     <= '0;
      word_idx  <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      overflow  <= 1'b0;
    end else begin
      mem_we <= 1'b0;
      case (state)
        IDLE: begin
          if (accept && (in_data == SYNC)) begin
            state    <= CNT_LO;
            overflow <= 1'b0;
            word_idx <= '0;
          end
        end
        CNT_LO: begin
          if (accept) begin
            count[7:0] <= in_data;
            state      <= CNT_HI;
          end
        end
        CNT_HI: begin
          if (accept) begin
            count[15:8] <= in_data;
            state       <= ({in_data, count[7:0]} == 16'd0) ? DONE : DATA;
          end
        end
        DATA: begin
          if (pk_last) begin
            state <= WRITE;
            if ({1'b0, word_idx} < DEPTH) begin
              mem_we    <= 1'b1;
              mem_addr  <= {14'd0, word_idx, 2'b00};
              mem_wdata <= next_word;
            end else begin
              overflow <= 1'b1;
            end
          end
        end
        WRITE: begin
          word_idx <= word_idx + 16'd1;
          state    <= ((word_idx + 16'd1) == count) ? DONE : DATA;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
